ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, and so on) from the system to the keyboard. It owns the open-drain drive of KBD_CLK and KBD_DATA during a transfer and follows the PS/2 host-to-device frame: inhibit, request-to-send, start bit, 8 data bits LSB first, odd parity, stop bit and device ACK. It sits beside the keyboard receiver in `kbd` and holds `rxInhibit` high so the receiver ignores clock activity caused by its own transmissions.

## Interface
- `CLK_HZ`, 25_000_000: system clock frequency. Informational only; no logic derives values from it.
- `INHIBIT_CYCLES`, 3000: cycles KBD_CLK is held low before the request (≥100 µs at 25 MHz).
- `FIRST_EDGE_CYCLES`, 375000: maximum wait from clock release to the first device falling edge (15 ms).
- `BIT_CYCLES`, 50000: maximum gap between consecutive device falling edges, and from the 11th edge to line release (2 ms).

- `clk`  in  1  system clock.
- `resetn`  in  1  synchronous, active-low reset.
- `txData`  in  8  command byte, captured when `txValid & txReady`.
- `txValid`  in  1  request to send.
- `txReady`  out  1  high only in IDLE.
- `txDone`  out  1  one-cycle pulse: byte sent and the device ACKed.
- `txError`  out  1  one-cycle pulse: timeout or missing ACK.
- `KBD_CLK_IN`  in  1  raw pad level of KBD_CLK (asynchronous).
- `KBD_DATA_IN`  in  1  raw pad level of KBD_DATA (asynchronous).
- `kbdClkDrvLow`  out  1  1 means the pad drives KBD_CLK low; 0 means released.
- `kbdDataDrvLow`  out  1  1 means the pad drives KBD_DATA low; 0 means released.
- `rxInhibit`  out  1  high whenever the state is not IDLE.

## Operation
- Both pad inputs pass through a 2-FF synchronizer. A device falling edge (`fe`) is registered sync-high followed by sync-low.
- All outputs are registered. Reset values: `txReady`=0, then 1 from the first cycle after reset; every other output is 0.
- The FSM states, in order, are IDLE, INHIBIT, REQ, BITS, ACK, RELEASE.
- **IDLE:** on `txValid`, latch `{parity, txData}` with parity = ~^txData (odd). Set `kbdClkDrvLow`=1, clear the counter, go to INHIBIT.
- **INHIBIT:** count to INHIBIT_CYCLES. Then set `kbdDataDrvLow`=1 (start bit) and go to REQ.
- **REQ:** lasts exactly 1 cycle. Set `kbdClkDrvLow`=0, clear the counter and the bit index, go to BITS.
- **BITS:** on `fe` number k (k = 1..10):
  - k = 1..8: `kbdDataDrvLow` = ~data[k-1].
  - k = 9: `kbdDataDrvLow` = ~parity.
  - k = 10: `kbdDataDrvLow` = 0 (stop bit). Go to ACK.
  - The counter clears on every `fe`.
- **ACK:** on the 11th `fe`, sample synchronized data. Low means the device ACKed: go to RELEASE. High means no ACK: go to error.
- **RELEASE:** wait until synchronized clock and data are both high. Then pulse `txDone` and go to IDLE.
- **Timeouts:**
  - Before the first `fe`, the limit is FIRST_EDGE_CYCLES.
  - After the first `fe`, the limit is BIT_CYCLES; this also applies in ACK and RELEASE.
  - On expiry, go to error.
- **Error:** release both lines, pulse `txError`, go to IDLE. The two lines are released in the same cycle `txError` is high.
- **Boundaries and concurrency:**
  - `txValid` is ignored outside IDLE. No queuing.
  - A device byte arriving during INHIBIT is the receiver's concern; this block never aborts because of it.
  - Reset mid-transfer releases both lines on the next edge and drops the frame.

## Timing
- `txReady` falls the cycle after acceptance.
- `kbdClkDrvLow` rises 1 cycle after acceptance.
- `kbdDataDrvLow` rises INHIBIT_CYCLES+1 cycles after `kbdClkDrvLow`.
- The clock is released exactly 1 cycle later.
- Data output changes 4 cycles after the pad's falling edge: 2 for sync, 1 for edge detect, 1 for the output register. This is far inside the device's ~30 µs low phase.
- `txDone` or `txError` is high for exactly 1 cycle. `txReady` returns the following cycle.
- The counter is 19 bits and saturating. Comparisons use `>=`.

## Structure
- Put the PS/2 command codes in the shared `vgaminikbd.vh`: `PS2_CMD_LED`=8'hED, `PS2_CMD_RESET`=8'hFF, `PS2_CMD_ENABLE`=8'hF4, `PS2_RSP_ACK`=8'hFA.
- Put the state encodings in the same header.
- Make one sub-module, `ps2_line_sync`: a 2-FF synchronizer plus falling-edge detector for one line. Instantiate it for clock and for data.

## Test plan
- **Send 0xED, BFM ACKs:** bits driven are 1,0,1,1,0,1,1,1, parity 1, then stop. Expect one `txDone`, no `txError`, both lines released.
- **Send 0xF4:** parity 0, so `kbdDataDrvLow`=1 after edge 9. Expect `txDone`.
- **Send 0xFF, BFM leaves data high on edge 11:** expect one `txError`, no `txDone`, `txReady` back the cycle after.
- **Device never clocks:** expect `txError` FIRST_EDGE_CYCLES+1 cycles after REQ, with `kbdClkDrvLow`=`kbdDataDrvLow`=0.
- **Device stops after edge 5:** expect `txError` BIT_CYCLES after edge 5. Also `txValid` held during a transfer must not be re-accepted.
- **resetn pulsed low during BITS:** both lines released and all outputs 0 the next cycle. A new 0xED afterwards completes normally.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmitter definitions: command codes, FSM state
// encoding, counter width and the odd-parity helper.
package ps2_host_tx_pkg;

    localparam logic [7:0] PS2_CMD_LED    = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

    // Timeout / inhibit counter width (saturating)
    localparam int CNT_W = 19;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_BITS    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } txState_t;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd
    function automatic logic oddParity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad plus a registered falling-edge flag.
// Lines idle high, so every stage resets to 1 to avoid a false edge.
module ps2_line_sync (
    input  logic clk,
    input  logic resetn,
    input  logic lineIn,
    output logic lineSync,
    output logic fallEdge
);

    logic metaR;
    logic syncR;
    logic prevR;

    // Synchronize the pad and flag a high-to-low transition one cycle later
    always_ff @(posedge clk) begin
        if (!resetn) begin
            metaR    <= 1'b1;
            syncR    <= 1'b1;
            prevR    <= 1'b1;
            fallEdge <= 1'b0;
        end else begin
            metaR    <= lineIn;
            syncR    <= metaR;
            prevR    <= syncR;
            fallEdge <= prevR & ~syncR;
        end
    end

    assign lineSync = syncR;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB
// first, odd parity, stop bit, device ACK, then wait for line release.
// All outputs are registered; the comb block computes their next values.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_HZ            = 25_000_000,
    parameter int INHIBIT_CYCLES    = 3000,
    parameter int FIRST_EDGE_CYCLES = 375000,
    parameter int BIT_CYCLES        = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       txDone,
    output logic       txError,
    input  logic       KBD_CLK_IN,
    input  logic       KBD_DATA_IN,
    output logic       kbdClkDrvLow,
    output logic       kbdDataDrvLow,
    output logic       rxInhibit
);

    // CLK_HZ documents the clock the limits were chosen for; nothing scales from it
    localparam int clkHzUnused = CLK_HZ;

    localparam logic [CNT_W-1:0] INH_LIM   = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] FIRST_LIM = CNT_W'(FIRST_EDGE_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LIM   = CNT_W'(BIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic clkSync, clkFe;
    logic dataSync, dataFeUnused;

    ps2_line_sync uClkSync (
        .clk      (clk),
        .resetn   (resetn),
        .lineIn   (KBD_CLK_IN),
        .lineSync (clkSync),
        .fallEdge (clkFe)
    );

    ps2_line_sync uDataSync (
        .clk      (clk),
        .resetn   (resetn),
        .lineIn   (KBD_DATA_IN),
        .lineSync (dataSync),
        .fallEdge (dataFeUnused)
    );

    txState_t         state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [3:0]       bitIdx, bitIdxNext;
    logic [8:0]       frame, frameNext;
    logic             readyNext, doneNext, errorNext;
    logic             clkDrvNext, dataDrvNext, inhibitNext;
    logic             accept, failNow;

    assign accept = (state == ST_IDLE) && txValid && txReady;

    // Next-state, datapath and next-output logic
    always_comb begin
        stateNext   = state;
        cntNext     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        bitIdxNext  = bitIdx;
        frameNext   = frame;
        clkDrvNext  = kbdClkDrvLow;
        dataDrvNext = kbdDataDrvLow;
        doneNext    = 1'b0;
        errorNext   = 1'b0;
        failNow     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    frameNext  = {oddParity(txData), txData};
                    clkDrvNext = 1'b1;
                    cntNext    = '0;
                    stateNext  = ST_INHIBIT;
                end else begin
                    clkDrvNext  = 1'b0;
                    dataDrvNext = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (cnt >= INH_LIM) begin
                    dataDrvNext = 1'b1;
                    stateNext   = ST_REQ;
                end else begin
                    stateNext = ST_INHIBIT;
                end
            end
            ST_REQ: begin
                clkDrvNext = 1'b0;
                cntNext    = '0;
                bitIdxNext = 4'd0;
                stateNext  = ST_BITS;
            end
            ST_BITS: begin
                if (clkFe) begin
                    cntNext    = '0;
                    bitIdxNext = bitIdx + 4'd1;
                    if (bitIdx < 4'd9) begin
                        // Edges 1..9 present data bits 0..7 then parity
                        dataDrvNext = ~frame[bitIdx];
                    end else begin
                        // Edge 10: release data for the stop bit
                        dataDrvNext = 1'b0;
                        stateNext   = ST_ACK;
                    end
                end else if (cnt >= ((bitIdx == 4'd0) ? FIRST_LIM : BIT_LIM)) begin
                    failNow = 1'b1;
                end else begin
                    stateNext = ST_BITS;
                end
            end
            ST_ACK: begin
                if (clkFe) begin
                    cntNext = '0;
                    if (!dataSync) begin
                        stateNext = ST_RELEASE;
                    end else begin
                        failNow = 1'b1;
                    end
                end else if (cnt >= BIT_LIM) begin
                    failNow = 1'b1;
                end else begin
                    stateNext = ST_ACK;
                end
            end
            ST_RELEASE: begin
                if (clkSync && dataSync) begin
                    doneNext  = 1'b1;
                    stateNext = ST_IDLE;
                end else if (cnt >= BIT_LIM) begin
                    failNow = 1'b1;
                end else begin
                    stateNext = ST_RELEASE;
                end
            end
            default: begin
                clkDrvNext  = 1'b0;
                dataDrvNext = 1'b0;
                stateNext   = ST_IDLE;
            end
        endcase

        // Any failure releases both lines in the same cycle the error pulses
        if (failNow) begin
            clkDrvNext  = 1'b0;
            dataDrvNext = 1'b0;
            errorNext   = 1'b1;
            stateNext   = ST_IDLE;
        end else begin
            errorNext = 1'b0;
        end

        // Ready only while idle and not in the accepting cycle; returns one
        // cycle after a done/error pulse because it looks at the current state
        readyNext   = (state == ST_IDLE) && !accept;
        inhibitNext = (stateNext != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bitIdx        <= 4'd0;
            frame         <= 9'd0;
            txReady       <= 1'b0;
            txDone        <= 1'b0;
            txError       <= 1'b0;
            kbdClkDrvLow  <= 1'b0;
            kbdDataDrvLow <= 1'b0;
            rxInhibit     <= 1'b0;
        end else begin
            state         <= stateNext;
            cnt           <= cntNext;
            bitIdx        <= bitIdxNext;
            frame         <= frameNext;
            txReady       <= readyNext;
            txDone        <= doneNext;
            txError       <= errorNext;
            kbdClkDrvLow  <= clkDrvNext;
            kbdDataDrvLow <= dataDrvNext;
            rxInhibit     <= inhibitNext;
        end
    end

endmodule
